router_fifo: RTL and testbench

Per-destination output buffer of the 1x3 router: one instance per output port, written by the router's write stage and drained by the destination reader through `read_enb`. Stores each byte with a header tag so it can track packet boundaries, driving `data_out`, `vld_out`, and a one-cycle `pkt_end` pulse when a packet's parity byte leaves the buffer. Supports a synchronous soft reset, used by the router when a destination stops reading.

---
 rtl/router_pkg.sv | 18 +
 rtl/router_fifo.sv | 85 ++++++++
 tb/tb_router_fifo.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared types and header helpers for the router output buffers.
package router_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;
  localparam int PLEN_W     = 6;

  typedef struct packed {
    logic                  hdr;
    logic [DEF_DATA_W-1:0] data;
  } fifo_entry_t;

  // Header layout: [7:2] payload length, [1:0] destination address.
  function automatic logic [PLEN_W-1:0] hdr_len(input logic [DEF_DATA_W-1:0] b);
    return b[DEF_DATA_W-1:2];
  endfunction

endpackage

// File: rtl/router_fifo.sv
// Per-destination output buffer: tagged FIFO that tracks packet boundaries
// and pulses pkt_end when a packet's parity byte is delivered.
module router_fifo
  import router_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              soft_reset,
  input  logic              write_enb,
  input  logic              lfd_state,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read_enb,
  output logic [DATA_W-1:0] data_out,
  output logic              vld_out,
  output logic              full,
  output logic              empty,
  output logic              pkt_end
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  fifo_entry_t mem [DEPTH];

  logic [AW:0]       wptr_r;
  logic [AW:0]       rptr_r;
  logic [PLEN_W:0]   pcnt_r;
  logic              wr_s;
  logic              rd_s;
  fifo_entry_t       rd_entry_s;

  // The extra pointer bit separates the full and empty cases at equal addresses.
  assign empty      = (wptr_r == rptr_r);
  assign full       = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
  assign vld_out    = !empty;
  assign wr_s       = write_enb && !full;
  assign rd_s       = read_enb && !empty;
  assign rd_entry_s = mem[rptr_r[AW-1:0]];

  // Storage array; contents survive both resets, only the pointers are cleared.
  always_ff @(posedge clock) begin
    if (wr_s && !soft_reset) begin
      mem[wptr_r[AW-1:0]] <= '{hdr: lfd_state, data: data_in};
    end
  end

  // Pointers, read data and packet byte counter.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wptr_r   <= '0;
      rptr_r   <= '0;
      pcnt_r   <= '0;
      data_out <= '0;
      pkt_end  <= 1'b0;
    end else if (soft_reset) begin
      wptr_r   <= '0;
      rptr_r   <= '0;
      pcnt_r   <= '0;
      data_out <= '0;
      pkt_end  <= 1'b0;
    end else begin
      pkt_end <= 1'b0;
      if (wr_s) begin
        wptr_r <= wptr_r + PTR_ONE;
      end
      if (rd_s) begin
        rptr_r   <= rptr_r + PTR_ONE;
        data_out <= rd_entry_s.data;
        if (rd_entry_s.hdr) begin
          // Payload bytes plus the trailing parity byte.
          pcnt_r <= {1'b0, hdr_len(rd_entry_s.data)} + 7'd1;
        end else if (pcnt_r != 7'd0) begin
          pcnt_r  <= pcnt_r - 7'd1;
          pkt_end <= (pcnt_r == 7'd1);
        end else begin
          pcnt_r <= 7'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_router_fifo.sv
// Randomized self-checking bench for router_fifo against a queue-based model.
module tb_router_fifo;

  localparam int DEPTH = 16;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       soft_reset = 1'b0;
  logic       write_enb = 1'b0;
  logic       lfd_state = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       read_enb = 1'b0;
  logic [7:0] data_out;
  logic       vld_out;
  logic       full;
  logic       empty;
  logic       pkt_end;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: queue of {tag, byte}, bytes left in current packet.
  logic [8:0] q[$];
  int         rem    = 0;
  logic [7:0] m_dout = 8'h00;
  logic       m_pend = 1'b0;

  router_fifo #(.DATA_W(8), .DEPTH(DEPTH)) dut (
    .clock(clock), .resetn(resetn), .soft_reset(soft_reset),
    .write_enb(write_enb), .lfd_state(lfd_state), .data_in(data_in),
    .read_enb(read_enb), .data_out(data_out), .vld_out(vld_out),
    .full(full), .empty(empty), .pkt_end(pkt_end)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock cycle of stimulus; model advanced at the edge, outputs stable #1 later.
  task automatic drive(input logic we, input logic lfd, input logic [7:0] din,
                       input logic re, input logic srst);
    logic [8:0] e;
    bit wacc;
    bit racc;
    write_enb = we; lfd_state = lfd; data_in = din; read_enb = re; soft_reset = srst;
    wacc = we && (q.size() < DEPTH);
    racc = re && (q.size() > 0);
    @(posedge clock);
    if (srst) begin
      q.delete(); rem = 0; m_dout = 8'h00; m_pend = 1'b0;
    end else begin
      m_pend = 1'b0;
      if (racc) begin
        e = q.pop_front();
        m_dout = e[7:0];
        if (e[8]) rem = int'(e[7:2]) + 1;
        else if (rem > 0) begin
          rem--;
          m_pend = (rem == 0);
        end
      end
      if (wacc) q.push_back({lfd, din});
    end
    #1;
    write_enb = 1'b0; lfd_state = 1'b0; read_enb = 1'b0; soft_reset = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty); end
    n_tests++; if (vld_out !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b expected 0", vld_out); end
    n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", full); end
    n_tests++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h expected 00", data_out); end
    n_tests++; if (pkt_end !== 1'b0) begin n_fail++; $display("FAIL reset_pkt_end: got %b expected 0", pkt_end); end
    #4 resetn = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 8'h31 + 8'(i), 1'b0, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    n_tests++; if (data_out !== m_dout) begin n_fail++; $display("FAIL ares_pre_dout: got %h expected %h", data_out, m_dout); end
    #2 resetn = 1'b0;
    #1;
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL ares_empty: got %b expected 1", empty); end
    n_tests++; if (vld_out !== 1'b0) begin n_fail++; $display("FAIL ares_vld: got %b expected 0", vld_out); end
    n_tests++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL ares_dout: got %h expected 00", data_out); end
    q.delete(); rem = 0; m_dout = 8'h00; m_pend = 1'b0;
    resetn = 1'b1;
    @(posedge clock); #1;
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL ares_post_empty: got %b expected 1", empty); end
  endtask

  task automatic test_single_packet;
    logic [7:0] pkt [5];
    pkt[0] = 8'h0C; pkt[1] = 8'h11; pkt[2] = 8'h22; pkt[3] = 8'h33; pkt[4] = 8'h1C;
    for (int i = 0; i < 5; i++) drive(1'b1, (i == 0), pkt[i], 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      n_tests++; if (data_out !== pkt[i]) begin n_fail++; $display("FAIL single_dout[%0d]: got %h expected %h", i, data_out, pkt[i]); end
      n_tests++; if (pkt_end !== (i == 4)) begin n_fail++; $display("FAIL single_pkt_end[%0d]: got %b expected %b", i, pkt_end, (i == 4)); end
    end
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL single_empty: got %b expected 1", empty); end
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    n_tests++; if (pkt_end !== 1'b0) begin n_fail++; $display("FAIL single_pulse_width: got %b expected 0", pkt_end); end
    n_tests++; if (data_out !== 8'h1C) begin n_fail++; $display("FAIL single_hold: got %h expected 1c", data_out); end
  endtask

  task automatic test_full;
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0, 8'($urandom_range(0, 127)), 1'b0, 1'b0);
    n_tests++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_set: got %b expected 1", full); end
    drive(1'b1, 1'b0, 8'hAA, 1'b0, 1'b0);
    n_tests++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_after_drop: got %b expected 1", full); end
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      n_tests++; if (data_out !== m_dout || data_out === 8'hAA) begin n_fail++; $display("FAIL full_drain[%0d]: got %h expected %h", i, data_out, m_dout); end
    end
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL full_drained_empty: got %b expected 1", empty); end
  endtask

  task automatic test_simultaneous;
    logic [7:0] prev;
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0, 8'($urandom_range(0, 127)), 1'b0, 1'b0);
    drive(1'b1, 1'b0, 8'hD5, 1'b1, 1'b0);
    n_tests++; if (full !== 1'b0 || empty !== 1'b0) begin n_fail++; $display("FAIL simul_full_occ: got full=%b empty=%b expected full=0 empty=0", full, empty); end
    n_tests++; if (data_out !== m_dout) begin n_fail++; $display("FAIL simul_full_dout: got %h expected %h", data_out, m_dout); end
    for (int i = 0; i < DEPTH - 1; i++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      n_tests++; if (data_out !== m_dout || data_out === 8'hD5) begin n_fail++; $display("FAIL simul_drain[%0d]: got %h expected %h", i, data_out, m_dout); end
    end
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL simul_drained: got %b expected 1", empty); end
    prev = data_out;
    drive(1'b1, 1'b0, 8'h66, 1'b1, 1'b0);
    n_tests++; if (data_out !== prev || empty !== 1'b0) begin n_fail++; $display("FAIL simul_empty: got dout=%h empty=%b expected dout=%h empty=0", data_out, empty, prev); end
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    n_tests++; if (data_out !== 8'h66 || empty !== 1'b1) begin n_fail++; $display("FAIL simul_empty_read: got dout=%h empty=%b expected dout=66 empty=1", data_out, empty); end
  endtask

  task automatic test_soft_reset;
    drive(1'b1, 1'b1, 8'h14, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    n_tests++; if (data_out !== m_dout) begin n_fail++; $display("FAIL srst_pre_dout: got %h expected %h", data_out, m_dout); end
    drive(1'b1, 1'b1, 8'h99, 1'b1, 1'b1);
    n_tests++; if (empty !== 1'b1 || data_out !== 8'h00 || pkt_end !== 1'b0) begin n_fail++; $display("FAIL srst_clear: got empty=%b dout=%h pkt_end=%b expected 1/00/0", empty, data_out, pkt_end); end
    drive(1'b1, 1'b1, 8'h04, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 8'h42, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 8'h46, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      n_tests++; if (data_out !== m_dout || pkt_end !== m_pend) begin n_fail++; $display("FAIL srst_pkt[%0d]: got dout=%h pkt_end=%b expected dout=%h pkt_end=%b", i, data_out, pkt_end, m_dout, m_pend); end
    end
    n_tests++; if (pkt_end !== 1'b1) begin n_fail++; $display("FAIL srst_pkt_end_parity: got %b expected 1", pkt_end); end
  endtask

  task automatic test_wrap;
    int writes = 0;
    logic we, re, lfd;
    for (int cyc = 0; cyc < 400 && writes < 40; cyc++) begin
      we  = ($urandom_range(0, 9) < 6);
      re  = ($urandom_range(0, 9) < 5);
      lfd = ($urandom_range(0, 7) == 0);
      if (we && q.size() < DEPTH) writes++;
      drive(we, lfd, 8'($urandom), re, 1'b0);
      n_tests++; if (full !== (q.size() == DEPTH) || empty !== (q.size() == 0) || vld_out !== (q.size() != 0)) begin n_fail++; $display("FAIL wrap_flags[%0d]: got full=%b empty=%b vld=%b expected occupancy %0d", cyc, full, empty, vld_out, q.size()); end
      n_tests++; if (data_out !== m_dout || pkt_end !== m_pend) begin n_fail++; $display("FAIL wrap_data[%0d]: got dout=%h pkt_end=%b expected dout=%h pkt_end=%b", cyc, data_out, pkt_end, m_dout, m_pend); end
    end
    n_tests++; if (writes < 40) begin n_fail++; $display("FAIL wrap_budget: got %0d writes expected 40", writes); end
    for (int i = 0; i < DEPTH + 1 && q.size() > 0; i++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      n_tests++; if (data_out !== m_dout || pkt_end !== m_pend) begin n_fail++; $display("FAIL wrap_drain[%0d]: got dout=%h pkt_end=%b expected dout=%h pkt_end=%b", i, data_out, pkt_end, m_dout, m_pend); end
    end
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL wrap_final_empty: got %b expected 1", empty); end
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_single_packet();
    test_full();
    test_simultaneous();
    test_soft_reset();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
